// File: rtl/xeng_correction_applier.sv
// Subtracts buffered, scaled per-baseline corrections from raw X-engine words.
// Define CORR_SATURATE_EN to clamp results (flagged in err_o[3]) instead of wrapping.
module xeng_correction_applier #(
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int P_FACTOR_BITS       = 2,
  parameter int BITWIDTH            = 4,
  parameter int XENG_WIDTH          = 24,
  parameter int CORR_SHIFT          = 3,
  parameter int FIFO_DEPTH          = 32,
  localparam int CORR_WIDTH = P_FACTOR_BITS + SERIAL_ACC_LEN_BITS + BITWIDTH + 3
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         sync_i,
  input  logic                         corr_vld_i,
  input  logic signed [CORR_WIDTH-1:0] re_corr_i,
  input  logic signed [CORR_WIDTH-1:0] im_corr_i,
  input  logic                         corr_last_i,
  input  logic                         corr_buf_sel_i,
  input  logic                         din_vld_i,
  input  logic signed [XENG_WIDTH-1:0] din_re_i,
  input  logic signed [XENG_WIDTH-1:0] din_im_i,
  input  logic                         din_buf_sel_i,
  output logic                         dout_vld_o,
  output logic signed [XENG_WIDTH-1:0] dout_re_o,
  output logic signed [XENG_WIDTH-1:0] dout_im_o,
  output logic                         dout_last_o,
  output logic                         dout_buf_sel_o,
  output logic [3:0]                   err_o
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int EW   = 2 * CORR_WIDTH + 2;
  localparam int DW   = XENG_WIDTH + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;

  logic                  s1_vld_q, s1_vld_d;
  logic signed [DW-1:0]  s1_re_q, s1_re_d, s1_im_q, s1_im_d;
  logic                  s1_last_q, s1_last_d, s1_bsel_q, s1_bsel_d;

  logic                         dout_vld_q, dout_vld_d;
  logic [XENG_WIDTH-1:0]        dout_re_q, dout_re_d, dout_im_q, dout_im_d;
  logic                         dout_last_q, dout_last_d, dout_bsel_q, dout_bsel_d;
  logic [3:0]                   err_q, err_d;

  logic active, fifo_empty, fifo_full;
  logic push_req, push_real, pop, pop_real;
  logic underflow, overflow, mismatch, sat_evt;
  logic [EW-1:0] head, push_entry;
  logic signed [CORR_WIDTH-1:0] corr_re, corr_im;
  logic signed [DW-1:0] corr_re_ext, corr_im_ext, din_re_ext, din_im_ext;

  assign active     = (state_q != ST_IDLE);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNTW'(FIFO_DEPTH));
  assign push_req   = active && corr_vld_i && !sync_i;
  assign pop        = active && din_vld_i;
  assign pop_real   = pop && !fifo_empty;
  assign push_real  = push_req && (!fifo_full || pop_real);
  assign underflow  = pop && fifo_empty;
  assign overflow   = push_req && fifo_full && !pop_real;
  assign head       = mem_q[rd_ptr_q];
  assign push_entry = {corr_buf_sel_i, corr_last_i, im_corr_i, re_corr_i};
  assign mismatch   = pop_real && (head[2*CORR_WIDTH+1] != din_buf_sel_i);

  // Control: state, FIFO pointers; sync flushes everything queued this cycle.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case (state_q)
      ST_IDLE:  if (sync_i) state_d = ST_ARMED;
      ST_ARMED: if (sync_i) state_d = ST_ARMED;
                else if (din_vld_i) state_d = ST_RUN;
      ST_RUN:   if (sync_i) state_d = ST_ARMED;
      default:  state_d = ST_IDLE;
    endcase
    if (active && sync_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_real) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_real)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_real, pop_real})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    corr_re     = underflow ? '0 : head[CORR_WIDTH-1:0];
    corr_im     = underflow ? '0 : head[2*CORR_WIDTH-1:CORR_WIDTH];
    corr_re_ext = DW'(corr_re);
    corr_im_ext = DW'(corr_im);
    din_re_ext  = DW'(din_re_i);
    din_im_ext  = DW'(din_im_i);
    s1_vld_d    = pop;
    s1_re_q_hold: begin end
    s1_re_d     = pop ? (din_re_ext - (corr_re_ext <<< CORR_SHIFT)) : s1_re_q;
    s1_im_d     = pop ? (din_im_ext - (corr_im_ext <<< CORR_SHIFT)) : s1_im_q;
    s1_last_d   = pop ? (underflow ? 1'b0 : head[2*CORR_WIDTH]) : s1_last_q;
    s1_bsel_d   = pop ? (underflow ? din_buf_sel_i : head[2*CORR_WIDTH+1]) : s1_bsel_q;
  end

  // Stage 2 narrows the 25-bit difference back to the output width.
  always_comb begin
    dout_vld_d  = s1_vld_q;
    dout_re_d   = dout_re_q;
    dout_im_d   = dout_im_q;
    dout_last_d = dout_last_q;
    dout_bsel_d = dout_bsel_q;
    sat_evt     = 1'b0;
    if (s1_vld_q) begin
      dout_last_d = s1_last_q;
      dout_bsel_d = s1_bsel_q;
`ifdef CORR_SATURATE_EN
      if (s1_re_q[DW-1] != s1_re_q[DW-2]) begin
        dout_re_d = s1_re_q[DW-1] ? {1'b1, {(XENG_WIDTH-1){1'b0}}} : {1'b0, {(XENG_WIDTH-1){1'b1}}};
        sat_evt   = 1'b1;
      end else begin
        dout_re_d = s1_re_q[XENG_WIDTH-1:0];
      end
      if (s1_im_q[DW-1] != s1_im_q[DW-2]) begin
        dout_im_d = s1_im_q[DW-1] ? {1'b1, {(XENG_WIDTH-1){1'b0}}} : {1'b0, {(XENG_WIDTH-1){1'b1}}};
        sat_evt   = 1'b1;
      end else begin
        dout_im_d = s1_im_q[XENG_WIDTH-1:0];
      end
`else
      dout_re_d = s1_re_q[XENG_WIDTH-1:0];
      dout_im_d = s1_im_q[XENG_WIDTH-1:0];
`endif
    end
    err_d = err_q | {sat_evt, mismatch, overflow, underflow};
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i && push_real) mem_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      s1_vld_q    <= 1'b0;
      s1_re_q     <= '0;
      s1_im_q     <= '0;
      s1_last_q   <= 1'b0;
      s1_bsel_q   <= 1'b0;
      dout_vld_q  <= 1'b0;
      dout_re_q   <= '0;
      dout_im_q   <= '0;
      dout_last_q <= 1'b0;
      dout_bsel_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      s1_vld_q    <= s1_vld_d;
      s1_re_q     <= s1_re_d;
      s1_im_q     <= s1_im_d;
      s1_last_q   <= s1_last_d;
      s1_bsel_q   <= s1_bsel_d;
      dout_vld_q  <= dout_vld_d;
      dout_re_q   <= dout_re_d;
      dout_im_q   <= dout_im_d;
      dout_last_q <= dout_last_d;
      dout_bsel_q <= dout_bsel_d;
      err_q       <= err_d;
    end
  end

  assign dout_vld_o     = dout_vld_q;
  assign dout_re_o      = dout_re_q;
  assign dout_im_o      = dout_im_q;
  assign dout_last_o    = dout_last_q;
  assign dout_buf_sel_o = dout_bsel_q;
  assign err_o          = err_q;

endmodule
